ysq_host_driver: RTL
====================

// Module: ysq_host_driver
// PURPOSE
//  Host-side end of the tt_um_ysquare pin interface: accepts operands on a valid/ready
//  request port, drives the DUT pins, captures the two-beat 16-bit square from the pins,
//  self-checks it against x*x, and returns it on a valid/ready response port.
//  Sits in the FPGA/bench harness opposite tt_um_ysquare; replaces ad-hoc pin poking.
//  Pin protocol: ui_in=x, uio_in[0]=start (1-cycle pulse); DUT raises uio_out[1]=rvalid
//  for 2 consecutive cycles: beat0 uo_out=y[7:0], beat1 uo_out=y[15:8].
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles from start pulse to beat0 before abort (>=2)
//  CHECK_EN        1   1: compare captured y to x*x, set rsp_err on mismatch; 0: rsp_err=0
// PORTS
//  clk          in   1   single clock; all logic rising-edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   operand request valid
//  req_ready    out  1   high only in IDLE
//  req_x        in   8   operand, sampled when req_valid&&req_ready
//  rsp_valid    out  1   response valid, held until rsp_ready
//  rsp_ready    in   1   response consumer ready
//  rsp_y        out  16  captured square {beat1,beat0}; 16'h0000 on timeout
//  rsp_err      out  1   mismatch vs x*x (CHECK_EN=1)
//  rsp_timeout  out  1   no rvalid within TIMEOUT_CYCLES
//  dut_ena      out  1   DUT enable
//  dut_ui_in    out  8   to DUT ui_in
//  dut_uio_in   out  8   to DUT uio_in; bits[7:1] always 0
//  dut_uo_out   in   8   from DUT uo_out
//  dut_uio_out  in   8   from DUT uio_out; only bit 1 used
//  pass_cnt     out  16  completed checked transactions with no error (saturating)
//  fail_cnt     out  16  transactions with rsp_err or rsp_timeout (saturating)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; req_ready=1; rsp_valid=0; rsp_y=0;
//   rsp_err=0; rsp_timeout=0; dut_ena=1; dut_ui_in=0; dut_uio_in=0; counters=0.
//  FSM: IDLE -> START -> WAIT -> HI -> RESP -> IDLE.
//  IDLE: on req_valid: latch x into dut_ui_in (held stable until RESP exit), go START.
//  START: dut_uio_in[0]=1 for exactly this one cycle; timeout counter cleared; go WAIT.
//  WAIT: counter++ each cycle; dut_uio_out[1]=1 -> capture uo_out as y[7:0], go HI;
//   counter reaches TIMEOUT_CYCLES first -> rsp_timeout=1, rsp_y=0, go RESP.
//  HI: capture uo_out as y[15:8] unconditionally; if dut_uio_out[1]==0 here, rsp_err=1
//   (short burst). CHECK_EN: rsp_err |= (y != x*x), 8x8 unsigned -> 16-bit, no truncation.
//   Go RESP.
//  RESP: rsp_valid=1, outputs stable; on rsp_ready: update counters, go IDLE.
//   rsp_valid&&rsp_ready is the handshake; rsp_ready ignored outside RESP.
//  Min latency accept->rsp_valid: 4 cycles (rvalid the cycle after start).
//  Boundaries: rvalid seen in START ignored (stale); rvalid in IDLE ignored; timeout and
//   rvalid on same WAIT cycle -> rvalid wins; counters saturate at 16'hFFFF;
//   x=0 -> y=0; x=255 -> y=16'hFE01; reset mid-transaction aborts, no response emitted.
// STRUCTURE
//  Shared package ysq_pkg: state enum encoding, pin-bit indices (START_BIT=0, RVALID_BIT=1),
//   RESULT_W=16, OPERAND_W=8.
//  One natural sub-module: ysq_sat_counter (16-bit saturating incrementer, x2 instances).
//  Reference square computed inline (single 8x8 multiply, registered with x).
// TESTING
//  1. Model DUT rvalid 1 cycle after start, x=12 -> rsp_y=16'h0090, err=0, pass_cnt=1.
//  2. x=255, model latency 10 -> rsp_y=16'hFE01 at accept+13, req_ready low throughout.
//  3. Model never raises rvalid, TIMEOUT_CYCLES=64 -> rsp_timeout=1, rsp_y=0, fail_cnt=1.
//  4. Model returns y=16'h0091 for x=12 -> rsp_err=1; CHECK_EN=0 build -> rsp_err=0.
//  5. rsp_ready held low 20 cycles -> rsp_valid/rsp_y stable, no second start pulse.
//  6. rst_n low during WAIT -> all outputs at reset values next edge; new req works after.

Source files
------------

// File: rtl/ysq_pkg.sv
// Shared definitions for the tt_um_ysquare host-side driver: FSM encoding,
// pin-bit positions and datapath widths.
package ysq_pkg;

    localparam int OPERAND_W  = 8;
    localparam int RESULT_W   = 16;
    localparam int START_BIT  = 0;
    localparam int RVALID_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HI    = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/ysq_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module ysq_sat_counter
    import ysq_pkg::*;
#(
    parameter int W = RESULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ysq_host_driver.sv
// Host-side driver for the tt_um_ysquare pins: issues a start pulse, captures the
// two-beat square, checks it against x*x and hands it back over valid/ready.
module ysq_host_driver
    import ysq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter bit CHECK_EN       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPERAND_W-1:0] req_x,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_y,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 dut_ena,
    output logic [7:0]           dut_ui_in,
    output logic [7:0]           dut_uio_in,
    input  logic [7:0]           dut_uo_out,
    input  logic [7:0]           dut_uio_out,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [OPERAND_W-1:0]  x_q, x_d;
    logic [RESULT_W-1:0]   sq_q, sq_d;
    logic [RESULT_W-1:0]   y_q, y_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rvalid, hs;
    logic [RESULT_W-1:0]   y_full;
    logic                  unused_uio;

    assign rvalid     = dut_uio_out[RVALID_BIT];
    assign unused_uio = ^{dut_uio_out[7:RVALID_BIT+1], dut_uio_out[RVALID_BIT-1:0]};
    assign y_full     = {dut_uo_out, y_q[7:0]};
    assign hs         = (state_q == ST_RESP) && rsp_ready;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sq_d    = sq_q;
        y_d     = y_q;
        err_d   = err_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    x_d     = req_x;
                    sq_d    = {8'h00, req_x} * {8'h00, req_x};
                    y_d     = '0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            // rvalid during the start pulse belongs to an earlier request; ignore it
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rvalid) begin
                    y_d[7:0] = dut_uo_out;
                    state_d  = ST_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        to_d    = 1'b1;
                        y_d     = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_HI: begin
                y_d     = y_full;
                err_d   = !rvalid || (CHECK_EN && (y_full != sq_q));
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            sq_q    <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            sq_q    <= sq_d;
            y_q     <= y_d;
            err_q   <= err_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    ysq_sat_counter #(.W(16)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hs && !err_q && !to_q),
        .cnt   (pass_cnt)
    );

    ysq_sat_counter #(.W(16)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hs && (err_q || to_q)),
        .cnt   (fail_cnt)
    );

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_y       = y_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;
    assign dut_ena     = 1'b1;
    assign dut_ui_in   = x_q;
    assign dut_uio_in  = {7'b0, state_q == ST_START} << START_BIT;

endmodule
